// File: rtl/bw_r_cm_pkg.sv
// Shared constants and helpers for the bw_r_cm CAM family.
package bw_r_cm_pkg;

    localparam int unsigned CM_DEPTH     = 16;
    localparam int unsigned CM_WIDTH     = 40;
    localparam int unsigned CM_KEY_LO    = 8;
    localparam int unsigned CM_IDX_HI    = 17;
    // Wordline classification works on a zero-extended vector; DEPTH must not exceed this.
    localparam int unsigned CM_MAX_DEPTH = 64;

    typedef enum logic [1:0] {
        WL_ZERO  = 2'd0,
        WL_ONE   = 2'd1,
        WL_MULTI = 2'd2
    } wl_kind_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic wl_kind_e wl_kind(input logic [CM_MAX_DEPTH-1:0] v);
        if (v == '0) return WL_ZERO;
        if ((v & (v - 64'd1)) == '0) return WL_ONE;
        return WL_MULTI;
    endfunction

endpackage

// File: rtl/bw_r_cm_gen_if.sv
// Write/read/invalidate/lookup bundle of the bw_r_cm_gen CAM.
interface bw_r_cm_gen_if
    import bw_r_cm_pkg::*;
#(
    parameter int unsigned DEPTH  = CM_DEPTH,
    parameter int unsigned WIDTH  = CM_WIDTH,
    parameter int unsigned KEY_LO = CM_KEY_LO
);
    localparam int unsigned AW = clog2(DEPTH);

    logic                    write_en;
    logic [DEPTH-1:0]        adr_w;
    logic [WIDTH-1:0]        din;
    logic                    read_en;
    logic [DEPTH-1:0]        adr_r;
    logic [WIDTH-1:0]        dout;
    logic                    dout_vld;
    logic                    inv_en;
    logic [DEPTH-1:0]        inv_mask;
    logic                    lookup_en;
    logic [WIDTH-KEY_LO-1:0] key;
    logic [DEPTH-1:0]        match;
    logic [DEPTH-1:0]        match_idx;
    logic                    hit;
    logic [AW-1:0]           hit_id;
    logic                    multi_hit;
    logic                    wl_err;

    modport master (
        output write_en, adr_w, din, read_en, adr_r, inv_en, inv_mask, lookup_en, key,
        input  dout, dout_vld, match, match_idx, hit, hit_id, multi_hit, wl_err
    );

    modport slave (
        input  write_en, adr_w, din, read_en, adr_r, inv_en, inv_mask, lookup_en, key,
        output dout, dout_vld, match, match_idx, hit, hit_id, multi_hit, wl_err
    );

endinterface

// File: rtl/bw_r_cm_penc.sv
// Lowest-index-wins priority encoder with any/multiple-set flags.
module bw_r_cm_penc #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 4
) (
    input  logic [N-1:0]  vec_i,
    output logic [AW-1:0] id_o,
    output logic          any_o,
    output logic          multi_o
);

    always_comb begin
        id_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) id_o = AW'(i);
        end
    end

    assign any_o   = |vec_i;
    assign multi_o = (vec_i & (vec_i - N'(1))) != '0;

endmodule

// File: rtl/bw_r_cm_gen.sv
// Parametrised CAM: one write, one read (with write bypass), one lookup port, per-entry valid.
module bw_r_cm_gen
    import bw_r_cm_pkg::*;
#(
    parameter int unsigned DEPTH  = CM_DEPTH,
    parameter int unsigned WIDTH  = CM_WIDTH,
    parameter int unsigned KEY_LO = CM_KEY_LO,
    parameter int unsigned IDX_HI = CM_IDX_HI
) (
    input  logic          rclk,
    input  logic          rst_l,
    bw_r_cm_gen_if.slave  bus
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [WIDTH-1:0]        dout_q, dout_d;
    logic                    dout_vld_q, dout_vld_d;
    logic [DEPTH-1:0]        match_q, match_idx_q, match_c, midx_c;
    logic                    hit_q, multi_q, wl_err_q, wl_err_d;
    logic [AW-1:0]           hit_id_q;
    logic [AW-1:0]           pe_id;
    logic                    pe_any, pe_multi;
    logic [CM_MAX_DEPTH-1:0] aw_ext, ar_ext;
    wl_kind_e                aw_kind, ar_kind;
    logic                    wr_ok;
    logic [WIDTH-1:0]        rd_word;
    logic                    rd_vld;

    always_comb begin
        aw_ext = '0;
        ar_ext = '0;
        aw_ext[DEPTH-1:0] = bus.adr_w;
        ar_ext[DEPTH-1:0] = bus.adr_r;
    end

    assign aw_kind = wl_kind(aw_ext);
    assign ar_kind = wl_kind(ar_ext);
    assign wr_ok   = bus.write_en && (aw_kind == WL_ONE);

    always_ff @(posedge rclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && bus.adr_w[i]) mem_q[i] <= bus.din;
        end
    end

    // Write is OR-ed in after the invalidate so a same-entry write wins.
    assign vld_d = (vld_q & ~(bus.inv_en ? bus.inv_mask : '0)) | (wr_ok ? bus.adr_w : '0);

    always_comb begin
        rd_word = '0;
        rd_vld  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.adr_r[i]) begin
                rd_word = rd_word | mem_q[i];
                rd_vld  = rd_vld | vld_q[i];
            end
        end
    end

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        if (bus.read_en) begin
            if (ar_kind != WL_ONE) begin
                dout_d     = '1;
                dout_vld_d = 1'b0;
            end else if (wr_ok && (bus.adr_w == bus.adr_r)) begin
                dout_d     = bus.din;
                dout_vld_d = 1'b1;
            end else begin
                dout_d     = rd_word;
                dout_vld_d = rd_vld;
            end
        end
    end

    assign wl_err_d = wl_err_q
                    | (bus.write_en && (aw_kind == WL_MULTI))
                    | (bus.read_en  && (ar_kind == WL_MULTI));

    // Compare against pre-edge contents; this edge's write/invalidate is not visible yet.
    always_comb begin
        match_c = '0;
        midx_c  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_c[i] = vld_q[i] && (mem_q[i][WIDTH-1:KEY_LO] == bus.key);
            midx_c[i]  = vld_q[i] && (mem_q[i][IDX_HI:KEY_LO] == bus.key[IDX_HI-KEY_LO:0]);
        end
    end

    bw_r_cm_penc #(
        .N  (DEPTH),
        .AW (AW)
    ) u_penc (
        .vec_i   (match_c),
        .id_o    (pe_id),
        .any_o   (pe_any),
        .multi_o (pe_multi)
    );

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            vld_q       <= '0;
            dout_q      <= '1;
            dout_vld_q  <= 1'b0;
            match_q     <= '0;
            match_idx_q <= '0;
            hit_q       <= 1'b0;
            hit_id_q    <= '0;
            multi_q     <= 1'b0;
            wl_err_q    <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            match_q     <= bus.lookup_en ? match_c  : '0;
            match_idx_q <= bus.lookup_en ? midx_c   : '0;
            hit_q       <= bus.lookup_en && pe_any;
            hit_id_q    <= bus.lookup_en ? pe_id    : '0;
            multi_q     <= bus.lookup_en && pe_multi;
            wl_err_q    <= wl_err_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.match     = match_q;
    assign bus.match_idx = match_idx_q;
    assign bus.hit       = hit_q;
    assign bus.hit_id    = hit_id_q;
    assign bus.multi_hit = multi_q;
    assign bus.wl_err    = wl_err_q;

endmodule
